// File: rtl/llc_rst_flush_walker_pkg.sv
// Shared LLC cache types: geometry macros, the set index type and the reset/flush walker state.
// The walker's optional flushed-line counter is enabled by defining LLC_FLUSH_STATS_EN.
`ifndef LLC_SETS
`define LLC_SETS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 4
`endif
`ifndef LLC_NUM_PORTS
`define LLC_NUM_PORTS 4
`endif

package llc_rst_flush_walker_pkg;

  typedef logic [`LLC_SET_BITS-1:0]  llc_set_t;
  typedef logic [`LLC_NUM_PORTS-1:0] llc_way_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    RST_WALK,
    FLUSH_WALK,
    FLUSH_RSP
  } llc_rf_state_t;

  // LLC_SETS is a power of two, so the set counter wraps to 0 on its own after this index.
  localparam llc_set_t LLC_LAST_SET = llc_set_t'(`LLC_SETS - 1);

endpackage

// File: rtl/llc_rst_flush_walker_if.sv
// Request, completion and response signals between the LLC front-end, update stage and walker.
// flushed_lines exists only when LLC_FLUSH_STATS_EN is defined.
`ifndef LLC_SETS
`define LLC_SETS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 4
`endif
`ifndef LLC_NUM_PORTS
`define LLC_NUM_PORTS 4
`endif

interface llc_rst_flush_walker_if #(parameter int STATS_WIDTH = 16);
  import llc_rst_flush_walker_pkg::*;

  logic          rst_req;
  logic          flush_req;
  logic          incr_rst_flush_stalled_set;
  llc_way_mask_t wr_rst_flush;
  llc_set_t      rst_flush_stalled_set;
  logic          is_rst_to_resume;
  logic          is_flush_to_resume;
  logic          rst_flush_busy;
  logic          flush_done_valid;
  logic          flush_done_ready;
`ifdef LLC_FLUSH_STATS_EN
  logic [STATS_WIDTH-1:0] flushed_lines;
`else
  logic [STATS_WIDTH-1:0] unused_stats_width;
  assign unused_stats_width = '0;
`endif

  modport master (
    output rst_req, flush_req, incr_rst_flush_stalled_set, wr_rst_flush, flush_done_ready,
`ifdef LLC_FLUSH_STATS_EN
    input  flushed_lines,
`endif
    input  rst_flush_stalled_set, is_rst_to_resume, is_flush_to_resume, rst_flush_busy,
           flush_done_valid
  );

  modport slave (
    input  rst_req, flush_req, incr_rst_flush_stalled_set, wr_rst_flush, flush_done_ready,
`ifdef LLC_FLUSH_STATS_EN
    output flushed_lines,
`endif
    output rst_flush_stalled_set, is_rst_to_resume, is_flush_to_resume, rst_flush_busy,
           flush_done_valid
  );

endinterface

// File: rtl/llc_popcount.sv
// Combinational population count of a WIDTH-bit vector; only built with LLC_FLUSH_STATS_EN.
`ifdef LLC_FLUSH_STATS_EN
module llc_popcount #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule
`endif

// File: rtl/llc_rst_flush_walker.sv
// Walks every LLC set for reset invalidation or flush, queues one opposite-kind request,
// and returns a flush-done handshake. LLC_FLUSH_STATS_EN adds a saturating flushed-line count.
`ifndef LLC_SETS
`define LLC_SETS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 4
`endif
`ifndef LLC_NUM_PORTS
`define LLC_NUM_PORTS 4
`endif

module llc_rst_flush_walker
  import llc_rst_flush_walker_pkg::*;
#(
  parameter int STATS_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  llc_rst_flush_walker_if.slave bus
);

  llc_rf_state_t state_q, state_d;
  llc_set_t      set_q, set_d;
  logic          pend_rst_q, pend_rst_d;
  logic          pend_flush_q, pend_flush_d;
  logic          flush_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RST_WALK;
      set_q        <= '0;
      pend_rst_q   <= 1'b0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      pend_rst_q   <= pend_rst_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    pend_rst_d   = pend_rst_q;
    pend_flush_d = pend_flush_q;
    flush_start  = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous reset and flush runs the reset first and parks the flush.
        if (bus.rst_req) begin
          state_d      = RST_WALK;
          set_d        = '0;
          pend_flush_d = bus.flush_req;
        end else if (bus.flush_req) begin
          state_d     = FLUSH_WALK;
          set_d       = '0;
          flush_start = 1'b1;
        end
      end
      RST_WALK: begin
        if (bus.flush_req) pend_flush_d = 1'b1;
        if (bus.incr_rst_flush_stalled_set) begin
          set_d = set_q + 1'b1;
          if (set_q == LLC_LAST_SET) begin
            if (pend_flush_q || bus.flush_req) begin
              state_d      = FLUSH_WALK;
              pend_flush_d = 1'b0;
              flush_start  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      FLUSH_WALK: begin
        if (bus.rst_req) pend_rst_d = 1'b1;
        if (bus.incr_rst_flush_stalled_set) begin
          set_d = set_q + 1'b1;
          if (set_q == LLC_LAST_SET) state_d = FLUSH_RSP;
        end
      end
      FLUSH_RSP: begin
        if (bus.rst_req) pend_rst_d = 1'b1;
        if (bus.flush_done_ready) begin
          if (pend_rst_q || bus.rst_req) begin
            state_d    = RST_WALK;
            set_d      = '0;
            pend_rst_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rst_flush_stalled_set = set_q;
  assign bus.is_rst_to_resume      = (state_q == RST_WALK);
  assign bus.is_flush_to_resume    = (state_q == FLUSH_WALK);
  assign bus.rst_flush_busy        = (state_q != IDLE);
  assign bus.flush_done_valid      = (state_q == FLUSH_RSP);

`ifdef LLC_FLUSH_STATS_EN
  localparam int CW = $clog2(`LLC_NUM_PORTS + 1);

  logic [CW-1:0]          pc;
  logic [STATS_WIDTH-1:0] flushed_q, flushed_d;
  logic [STATS_WIDTH:0]   sum;

  llc_popcount #(.WIDTH(`LLC_NUM_PORTS), .CW(CW)) u_popcount (
    .bits  (bus.wr_rst_flush),
    .count (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flushed_q <= '0;
    else     flushed_q <= flushed_d;
  end

  // The extra sum bit flags overflow so the counter pins at all-ones instead of wrapping.
  always_comb begin
    flushed_d = flushed_q;
    sum       = {1'b0, flushed_q} + (STATS_WIDTH + 1)'(pc);
    if (flush_start) begin
      flushed_d = '0;
    end else if (state_q == FLUSH_WALK && bus.incr_rst_flush_stalled_set) begin
      flushed_d = sum[STATS_WIDTH] ? '1 : sum[STATS_WIDTH-1:0];
    end
  end

  assign bus.flushed_lines = flushed_q;
`else
  logic                   unused_inputs;
  logic [STATS_WIDTH-1:0] unused_stats;
  assign unused_inputs = ^{bus.wr_rst_flush, flush_start};
  assign unused_stats  = '0;
`endif

endmodule

// File: tb/tb_llc_rst_flush_walker.sv
// Self-checking bench for llc_rst_flush_walker: directed scenarios then random traffic against
// a job-queue reference model. Checks flushed_lines too when LLC_FLUSH_STATS_EN is defined.
`ifndef LLC_SETS
`define LLC_SETS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 4
`endif
`ifndef LLC_NUM_PORTS
`define LLC_NUM_PORTS 4
`endif

module tb_llc_rst_flush_walker;
  localparam int SW    = 4;
  localparam int SETS  = `LLC_SETS;
  localparam int NP    = `LLC_NUM_PORTS;
  localparam int SMAX  = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model: queue of outstanding jobs ("R" reset walk, "F" flush walk, "P" response).
  byte  q[$];
  int   m_set;
  int   m_stats;

  llc_rst_flush_walker_if #(.STATS_WIDTH(SW)) bus ();

  llc_rst_flush_walker #(.STATS_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic byte front();
    return (q.size() > 0) ? q[0] : "I";
  endfunction

  function automatic bit queued(input byte j);
    foreach (q[i]) if (q[i] == j) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    q.push_back("R");
    m_set   = 0;
    m_stats = 0;
  endfunction

  function automatic void model_step(input bit rq, input bit fq, input bit inc,
                                     input logic [NP-1:0] wr, input bit rdy);
    byte cur = front();
    if (cur == "I") begin
      if (rq) begin
        q.push_back("R");
        if (fq) begin q.push_back("F"); q.push_back("P"); end
      end else if (fq) begin
        q.push_back("F"); q.push_back("P");
        m_stats = 0;
      end
    end else if (cur == "R") begin
      if (fq && !queued("F")) begin q.push_back("F"); q.push_back("P"); end
    end else begin
      if (rq && !queued("R")) q.push_back("R");
    end
    if ((cur == "R" || cur == "F") && inc) begin
      if (cur == "F") begin
        m_stats = m_stats + $countones(wr);
        if (m_stats > SMAX) m_stats = SMAX;
      end
      m_set++;
      if (m_set == SETS) begin
        m_set = 0;
        void'(q.pop_front());
        if (front() == "F") m_stats = 0;
      end
    end
    if (cur == "P" && rdy) void'(q.pop_front());
  endfunction

  task automatic check_all(input string tag);
    byte f = front();
    checkOutput({tag, ".set"},   32'(bus.rst_flush_stalled_set), 32'(m_set));
    checkOutput({tag, ".rst"},   32'(bus.is_rst_to_resume),      32'(f == "R"));
    checkOutput({tag, ".flush"}, 32'(bus.is_flush_to_resume),    32'(f == "F"));
    checkOutput({tag, ".busy"},  32'(bus.rst_flush_busy),        32'(f != "I"));
    checkOutput({tag, ".valid"}, 32'(bus.flush_done_valid),      32'(f == "P"));
`ifdef LLC_FLUSH_STATS_EN
    checkOutput({tag, ".stats"}, 32'(bus.flushed_lines),         32'(m_stats));
`endif
  endtask

  task automatic applyStimulus(input string tag, input bit rq, input bit fq, input bit inc,
                               input logic [NP-1:0] wr, input bit rdy);
    bus.rst_req                    = rq;
    bus.flush_req                  = fq;
    bus.incr_rst_flush_stalled_set = inc;
    bus.wr_rst_flush               = wr;
    bus.flush_done_ready           = rdy;
    @(posedge clk);
    #1;
    model_step(rq, fq, inc, wr, rdy);
    bus.rst_req                    = 1'b0;
    bus.flush_req                  = 1'b0;
    bus.incr_rst_flush_stalled_set = 1'b0;
    bus.flush_done_ready           = 1'b0;
    check_all(tag);
  endtask

  task automatic walk(input string tag, input int n, input logic [NP-1:0] wr);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b1, wr, 1'b0);
  endtask

  // Asserts reset between edges so the outputs must react without a clock.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [NP-1:0] ones = '1;
    logic [NP-1:0] five = NP'(4'b0101);
    bus.rst_req                    = 1'b0;
    bus.flush_req                  = 1'b0;
    bus.incr_rst_flush_stalled_set = 1'b0;
    bus.wr_rst_flush               = '0;
    bus.flush_done_ready           = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    walk("rst_walk", SETS, '0);
    checkOutput("rst_walk_idle", 32'(bus.rst_flush_busy), 32'd0);

    applyStimulus("flush_start", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    walk("flush_ones", SETS, ones);
`ifdef LLC_FLUSH_STATS_EN
    checkOutput("stats_saturated", 32'(bus.flushed_lines), 32'd15);
`endif
    for (int i = 0; i < 5; i++) applyStimulus("rsp_hold", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("rsp_still_valid", 32'(bus.flush_done_valid), 32'd1);
    applyStimulus("rsp_accept", 1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("rsp_dropped", 32'(bus.flush_done_valid), 32'd0);

    applyStimulus("flush2_start", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus("flush2_set0", 1'b0, 1'b0, 1'b1, five, 1'b0);
    walk("flush2", SETS - 1, '0);
`ifdef LLC_FLUSH_STATS_EN
    checkOutput("stats_0101", 32'(bus.flushed_lines), 32'd2);
`endif
    applyStimulus("flush2_accept", 1'b0, 1'b0, 1'b0, '0, 1'b1);

    applyStimulus("both_req", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    walk("both_rst", SETS, '0);
    checkOutput("both_flush_active", 32'(bus.is_flush_to_resume), 32'd1);
    checkOutput("both_flush_set0", 32'(bus.rst_flush_stalled_set), 32'd0);
    walk("both_flush", SETS, ones);
    applyStimulus("both_accept", 1'b0, 1'b0, 1'b0, '0, 1'b1);

    applyStimulus("pend_flush", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    walk("pend_pre", 3, five);
    applyStimulus("pend_rstreq", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    walk("pend_post", SETS - 3, five);
    checkOutput("pend_rsp_valid", 32'(bus.flush_done_valid), 32'd1);
    applyStimulus("pend_accept", 1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("pend_rst_walk", 32'(bus.is_rst_to_resume), 32'd1);
    walk("pend_rst", SETS, '0);

    applyStimulus("arst_flush", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    walk("arst_pre", 7, ones);
    async_reset("arst_mid");
    checkOutput("arst_rst_walk", 32'(bus.is_rst_to_resume), 32'd1);
    walk("arst_rst", SETS, '0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rand_arst");
      end else begin
        applyStimulus("rand",
                      $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 6,
                      $urandom_range(0, 99) < 70,
                      NP'($urandom),
                      $urandom_range(0, 1) == 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
